// File: rtl/rs_multi_cdb_pkg.sv
// rs_multi_cdb_pkg: shared types for the reservation station and its users.
package rs_multi_cdb_pkg;
    localparam int DEF_PREG_W  = 6;
    localparam int DEF_NUM_CDB = 2;
    localparam int PAYLOAD_W   = 16;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_MEM = 2'd2,
        FU_BR  = 2'd3
    } fu_type_e;

    typedef struct packed {
        logic [DEF_PREG_W-1:0] num;
        logic                  ready;
    } reg_t;

    typedef struct packed {
        fu_type_e              fu;
        reg_t                  tag1;
        reg_t                  tag2;
        logic [DEF_PREG_W-1:0] dest;
        logic [PAYLOAD_W-1:0]  payload;
    } rs_packet_t;
endpackage

// File: rtl/rs_multi_cdb_prio_enc_lsb.sv
// prio_enc_lsb: index of the lowest set request bit, plus an any-set flag.
module prio_enc_lsb #(
    parameter int W  = 8,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req,
    output logic          found,
    output logic [IW-1:0] idx
);
    always_comb begin
        found = |req;
        idx   = '0;
        for (int i = W - 1; i >= 0; i--)
            if (req[i]) idx = IW'(i);
    end
endmodule

// File: rtl/rs_multi_cdb.sv
// rs_multi_cdb: unified reservation station snooping NUM_CDB completion buses,
// allocating into the lowest free slot and issuing the lowest ready slot.
module rs_multi_cdb
    import rs_multi_cdb_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int NUM_CDB     = DEF_NUM_CDB,
    parameter int PREG_W      = DEF_PREG_W,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           alloc_valid,
    input  rs_packet_t                     packet_in,
    output logic                           alloc_ready,
    input  logic [NUM_CDB-1:0]             cdb_valid,
    input  logic [NUM_CDB-1:0][PREG_W-1:0] cdb_tag,
    output logic                           issue_valid,
    input  logic                           issue_ready,
    output rs_packet_t                     issued_packet,
    output logic [IDX_W-1:0]               issue_index,
    input  logic                           flush,
    output logic [IDX_W:0]                 free_count
);
    logic [NUM_ENTRIES-1:0]              valid_q, valid_d, ready_vec;
    rs_packet_t                          slot_q [NUM_ENTRIES];
    rs_packet_t                          slot_d [NUM_ENTRIES];
    rs_packet_t                          in_pkt;
    logic [NUM_ENTRIES-1:0][NUM_CDB-1:0] hit1, hit2;
    logic [NUM_CDB-1:0]                  byp1, byp2;
    logic [IDX_W-1:0]                    alloc_idx, sel_idx;

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_slot
        for (genvar c = 0; c < NUM_CDB; c++) begin : g_cdb
            assign hit1[i][c] = cdb_valid[c] && (cdb_tag[c] == slot_q[i].tag1.num);
            assign hit2[i][c] = cdb_valid[c] && (cdb_tag[c] == slot_q[i].tag2.num);
        end
        assign ready_vec[i] = valid_q[i] && slot_q[i].tag1.ready && slot_q[i].tag2.ready;
    end

    for (genvar c = 0; c < NUM_CDB; c++) begin : g_byp
        assign byp1[c] = cdb_valid[c] && (cdb_tag[c] == packet_in.tag1.num);
        assign byp2[c] = cdb_valid[c] && (cdb_tag[c] == packet_in.tag2.num);
    end

    prio_enc_lsb #(.W(NUM_ENTRIES), .IW(IDX_W)) u_free (
        .req(~valid_q), .found(alloc_ready), .idx(alloc_idx)
    );

    prio_enc_lsb #(.W(NUM_ENTRIES), .IW(IDX_W)) u_sel (
        .req(ready_vec), .found(issue_valid), .idx(sel_idx)
    );

    assign issue_index   = issue_valid ? sel_idx : '0;
    assign issued_packet = issue_valid ? slot_q[sel_idx] : '0;

    always_comb begin
        free_count = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            free_count = free_count + (IDX_W+1)'(!valid_q[i]);
    end

    // Preg 0 is architecturally always ready; same-cycle broadcasts are bypassed in.
    always_comb begin
        in_pkt            = packet_in;
        in_pkt.tag1.ready = packet_in.tag1.ready || (|byp1) || (packet_in.tag1.num == '0);
        in_pkt.tag2.ready = packet_in.tag2.ready || (|byp2) || (packet_in.tag2.num == '0);
    end

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            slot_d[i]            = slot_q[i];
            slot_d[i].tag1.ready = slot_q[i].tag1.ready || (|hit1[i]);
            slot_d[i].tag2.ready = slot_q[i].tag2.ready || (|hit2[i]);
        end
        if (issue_valid && issue_ready) valid_d[sel_idx] = 1'b0;
        if (alloc_valid && alloc_ready) begin
            valid_d[alloc_idx] = 1'b1;
            slot_d[alloc_idx]  = in_pkt;
        end
        if (flush) valid_d = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) slot_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < NUM_ENTRIES; i++) slot_q[i] <= slot_d[i];
        end
    end
endmodule

// File: tb/tb_rs_multi_cdb.sv
// tb_rs_multi_cdb: directed checks of allocation, wakeup, bypass, issue and flush.
module tb_rs_multi_cdb;
    import rs_multi_cdb_pkg::*;

    logic            clock = 1'b0;
    logic            reset, alloc_valid, alloc_ready, issue_valid, issue_ready, flush;
    rs_packet_t      packet_in, issued_packet;
    logic [1:0]      cdb_valid;
    logic [1:0][5:0] cdb_tag;
    logic [2:0]      issue_index;
    logic [3:0]      free_count;
    int              tests = 0;
    int              fails = 0;

    rs_multi_cdb dut (
        .clock(clock), .reset(reset), .alloc_valid(alloc_valid), .packet_in(packet_in),
        .alloc_ready(alloc_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issued_packet(issued_packet),
        .issue_index(issue_index), .flush(flush), .free_count(free_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rs_packet_t mk(input logic [5:0] t1, input logic r1,
                                      input logic [5:0] t2, input logic r2,
                                      input logic [15:0] pl);
        rs_packet_t p;
        p.fu      = FU_ALU;
        p.tag1    = '{num: t1, ready: r1};
        p.tag2    = '{num: t2, ready: r2};
        p.dest    = 6'd33;
        p.payload = pl;
        return p;
    endfunction

    initial begin
        reset = 1'b1; alloc_valid = 1'b0; issue_ready = 1'b0; flush = 1'b0;
        packet_in = '0; cdb_valid = '0; cdb_tag = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_issue_index", issue_index, 0);
        chk("rst_issued_pkt", issued_packet, 0);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_free_count", free_count, 8);

        // Fill with ready packets, then drain in index order.
        alloc_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            packet_in = mk(6'd1, 1'b1, 6'd2, 1'b1, 16'h100 + 16'(i));
            chk("fill_free_count", free_count, 64'(8 - i));
            tick();
        end
        alloc_valid = 1'b0;
        chk("full_free_count", free_count, 0);
        chk("full_alloc_ready", alloc_ready, 0);
        issue_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", issue_valid, 1);
            chk("drain_index", issue_index, 64'(i));
            chk("drain_payload", issued_packet.payload, 64'h100 + 64'(i));
            tick();
        end
        issue_ready = 1'b0;
        chk("drain_free_count", free_count, 8);
        chk("drain_issue_valid", issue_valid, 0);

        // Fill waiting on preg 5 (tag2 is preg 0, always ready), reject a 9th.
        alloc_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            packet_in = mk(6'd5, 1'b0, 6'd0, 1'b0, 16'h200 + 16'(i));
            tick();
        end
        chk("wait_issue_valid", issue_valid, 0);
        chk("wait_alloc_ready", alloc_ready, 0);
        packet_in = mk(6'd0, 1'b1, 6'd0, 1'b1, 16'h2ff);
        tick();
        alloc_valid = 1'b0;
        chk("reject_free_count", free_count, 0);
        chk("reject_issue_valid", issue_valid, 0);
        cdb_valid = 2'b01; cdb_tag[0] = 6'd5; cdb_tag[1] = 6'd0;
        chk("same_cycle_wake", issue_valid, 0);
        tick();
        cdb_valid = 2'b00;
        chk("wake_issue_valid", issue_valid, 1);
        chk("wake_issue_index", issue_index, 0);
        chk("wake_payload", issued_packet.payload, 16'h200);
        chk("wake_tag1_ready", issued_packet.tag1.ready, 1);
        chk("zero_tag2_ready", issued_packet.tag2.ready, 1);
        issue_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("wake_drain_index", issue_index, 64'(i));
            tick();
        end
        issue_ready = 1'b0;
        chk("wake_drain_free", free_count, 8);

        // Allocate-time bypass on channel 1.
        alloc_valid = 1'b1;
        packet_in = mk(6'd0, 1'b0, 6'd9, 1'b0, 16'h300);
        cdb_valid = 2'b10; cdb_tag[0] = 6'd7; cdb_tag[1] = 6'd9;
        tick();
        alloc_valid = 1'b0; cdb_valid = 2'b00;
        chk("byp_issue_valid", issue_valid, 1);
        chk("byp_issue_index", issue_index, 0);
        chk("byp_tag2_ready", issued_packet.tag2.ready, 1);
        // A matching tag with the channel invalid must not wake.
        alloc_valid = 1'b1;
        issue_ready = 1'b1;
        packet_in = mk(6'd11, 1'b0, 6'd0, 1'b0, 16'h301);
        cdb_tag[0] = 6'd11; cdb_tag[1] = 6'd11;
        tick();
        alloc_valid = 1'b0; issue_ready = 1'b0;
        chk("nobyp_issue_valid", issue_valid, 0);
        chk("nobyp_free_count", free_count, 7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush1_free_count", free_count, 8);

        // Two slots woken by both channels in one cycle.
        alloc_valid = 1'b1;
        packet_in = mk(6'd3, 1'b0, 6'd0, 1'b0, 16'h400);
        tick();
        packet_in = mk(6'd0, 1'b0, 6'd4, 1'b0, 16'h401);
        tick();
        alloc_valid = 1'b0;
        chk("dual_pre_valid", issue_valid, 0);
        cdb_valid = 2'b11; cdb_tag[0] = 6'd4; cdb_tag[1] = 6'd3;
        tick();
        cdb_valid = 2'b00;
        issue_ready = 1'b1;
        chk("dual_valid0", issue_valid, 1);
        chk("dual_index0", issue_index, 0);
        tick();
        chk("dual_valid1", issue_valid, 1);
        chk("dual_index1", issue_index, 1);
        chk("dual_payload1", issued_packet.payload, 16'h401);
        tick();
        issue_ready = 1'b0;
        chk("dual_done_valid", issue_valid, 0);
        chk("dual_done_free", free_count, 8);

        // Stall: held issue stays stable and nothing is freed.
        alloc_valid = 1'b1;
        packet_in = mk(6'd1, 1'b1, 6'd2, 1'b1, 16'h500);
        tick();
        alloc_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", issue_valid, 1);
            chk("stall_index", issue_index, 0);
            chk("stall_payload", issued_packet.payload, 16'h500);
            chk("stall_free", free_count, 7);
            tick();
        end
        // Issue and alloc together: freed slot 0 is not the alloc target.
        issue_ready = 1'b1; alloc_valid = 1'b1;
        packet_in = mk(6'd1, 1'b1, 6'd2, 1'b1, 16'h501);
        tick();
        alloc_valid = 1'b0;
        chk("concur_index", issue_index, 1);
        chk("concur_payload", issued_packet.payload, 16'h501);
        chk("concur_free", free_count, 7);
        tick();
        issue_ready = 1'b0;
        chk("concur_done_free", free_count, 8);

        // Flush with 5 entries plus concurrent alloc and issue attempt.
        alloc_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            packet_in = mk(6'd20, 1'b0, 6'd0, 1'b0, 16'h600 + 16'(i));
            tick();
        end
        chk("preflush_free", free_count, 3);
        packet_in = mk(6'd1, 1'b1, 6'd2, 1'b1, 16'h6ff);
        flush = 1'b1; issue_ready = 1'b1;
        tick();
        flush = 1'b0; alloc_valid = 1'b0; issue_ready = 1'b0;
        chk("flush_free_count", free_count, 8);
        chk("flush_issue_valid", issue_valid, 0);
        chk("flush_alloc_ready", alloc_ready, 1);

        // Reset dominates a concurrent alloc.
        alloc_valid = 1'b1; reset = 1'b1;
        packet_in = mk(6'd1, 1'b1, 6'd2, 1'b1, 16'h700);
        tick();
        alloc_valid = 1'b0; reset = 1'b0;
        chk("rst_alloc_free", free_count, 8);
        chk("rst_alloc_issue", issue_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rs_multi_cdb.md
Name: rs_multi_cdb

Overview:
- Parametrised, unified reservation station. Holds up to NUM_ENTRIES renamed instructions (RS_PACKET) until both source physical registers are ready.
- Snoops NUM_CDB completion buses per cycle and issues one ready instruction per cycle to the FU side through a valid/ready handshake.
- Sits between dispatch/rename and the FU issue stage. Replaces fixed per-FU slots with a searchable free-list structure.

Parameters:
- NUM_ENTRIES, 8, number of RS slots (>=2). IDX_W = $clog2(NUM_ENTRIES).
- NUM_CDB, 2, number of CDB broadcast channels snooped each cycle (>=1).
- PREG_W, 6, physical register tag width. Must match REG.num in the shared package.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- alloc_valid  in  1  dispatch presents packet_in.
- packet_in  in  RS_PACKET  instruction: fu, tag1/tag2 {num, ready}, dest, payload.
- alloc_ready  out  1  at least one free slot (combinational from current state).
- cdb_valid  in  NUM_CDB  per-channel broadcast valid.
- cdb_tag  in  NUM_CDB x PREG_W  per-channel completing preg number.
- issue_valid  out  1  some entry has both operands ready.
- issue_ready  in  1  FU side accepts this cycle.
- issued_packet  out  RS_PACKET  selected entry, with tag readies as stored.
- issue_index  out  IDX_W  slot index of issued_packet.
- flush  in  1  squash all entries (mispredict recovery).
- free_count  out  IDX_W+1  number of invalid slots.

Behaviour:
- State per slot: valid bit plus RS_PACKET.
- Reset: all valid=0, issue_valid=0, issue_index=0, issued_packet=0, alloc_ready=1, free_count=NUM_ENTRIES.
- Allocation:
  - Fires when alloc_valid && alloc_ready.
  - Writes the lowest-index invalid slot at the clock edge and sets valid=1.
  - alloc_valid with alloc_ready=0 is ignored, and no state changes. Dispatch must hold the packet.
- Allocate-time bypass: if an incoming tagN.num matches any valid cdb_tag in the same cycle, the stored tagN.ready=1.
- Zero register: preg 0 is always ready. tagN.num==0 stores ready=1 regardless of packet_in.
- Wakeup:
  - At each edge, every valid slot sets tagN.ready=1 for any channel c with cdb_valid[c] && cdb_tag[c]==tagN.num.
  - Multiple channels may match; the result is idempotent.
- Issue select:
  - Combinational. Picks the lowest-index valid slot with tag1.ready && tag2.ready, evaluated on registered state.
  - issue_valid=1 iff such a slot exists. issued_packet and issue_index come from that slot.
  - When issue_valid=0, the outputs hold 0.
  - A same-cycle CDB match does not make a slot issuable until the next cycle (one-cycle wakeup-to-issue latency).
- Issue handshake: on issue_valid && issue_ready the selected slot is cleared at the edge. Minimum residency is 1 cycle (alloc at edge N, issue visible cycle N+1 if operands are ready).
- Simultaneous alloc and issue: the alloc target comes from current state. The slot freed by issue this cycle is not reused until next cycle. A full RS with an issue in the same cycle still rejects the allocation.
- Flush: at the edge, clears all valid bits. It takes priority over alloc, wakeup and issue; an alloc or issue in the flush cycle is dropped. The FU must ignore an issue handshake in a flush cycle.
- Reset has priority over flush and all other inputs.
- free_count: popcount of ~valid from registered state. alloc_ready = (free_count != 0).
- No entry ever holds valid=1 with a stale CDB match missed; wakeup applies to every valid slot every cycle.

Decomposition:
- Shared package: RS_PACKET, REG {num, ready}, FU_TYPE enum, and PREG_W/NUM_CDB defaults as localparams.
- Sub-module prio_enc_lsb (parametrised width, outputs found + index), instantiated twice: free-slot search and ready-slot select.
- Wakeup compare stays inline as a generate loop over slots x channels.

Test Plan:
- Reset, then alloc 8 packets with ready operands, issue_ready=1 -> issue order indices 0..7, one per cycle, free_count returns to 8.
- Fill all 8 slots with tag1=5 not ready, alloc a 9th -> alloc_ready=0, RS state unchanged. cdb_valid=01, cdb_tag[0]=5 -> next cycle issue_valid=1, index 0.
- Alloc with tag2=9 while cdb_tag[1]=9 valid in the same cycle -> stored tag2.ready=1, issued the following cycle.
- Two slots waiting on 3 and 4; one cycle with cdb_tag={4,3}, both valid -> both wake, issue index 0 then 1 on consecutive cycles.
- issue_ready=0 for 3 cycles with a ready entry -> issue_valid stays 1 with stable packet/index, and no slot is freed.
- Flush with 5 valid slots plus a concurrent alloc -> next cycle free_count=8, issue_valid=0.
